// File: rtl/cle_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cle_sram_arbiter
// Purpose  : Shares the single-port label SRAM between the CLE labeling/merge
//            core (requester 0) and the result-dump/clear engine (requester 1).
//            Per-cycle round-robin arbitration, with a lock that lets one
//            requester keep the port for atomic read-modify-write merges.
//            A lock held too long is forcibly released after MAX_LOCK cycles.
// Ports    : clk_i, reset_i            clock, async active-high reset
//            rK_req_i/wen_i/a_i/d_i    requester K access (wen active-low)
//            rK_lock_i                 requester K keeps ownership next cycle
//            rK_gnt_o                  access accepted this cycle (comb.)
//            rK_rvalid_o, rK_q_o       read data, one cycle after the grant
//            sram_q_i                  SRAM read data
//            sram_a_o/d_o/wen_o        SRAM address / data / write enable
//            lock_abort_o              pulse when a lock is forcibly released
// Revision : 1.0  initial release
// ============================================================================
module cle_sram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    // requester 0
    input  logic          r0_req_i,
    input  logic          r0_wen_i,
    input  logic [AW-1:0] r0_a_i,
    input  logic [DW-1:0] r0_d_i,
    input  logic          r0_lock_i,
    output logic          r0_gnt_o,
    output logic          r0_rvalid_o,
    output logic [DW-1:0] r0_q_o,
    // requester 1
    input  logic          r1_req_i,
    input  logic          r1_wen_i,
    input  logic [AW-1:0] r1_a_i,
    input  logic [DW-1:0] r1_d_i,
    input  logic          r1_lock_i,
    output logic          r1_gnt_o,
    output logic          r1_rvalid_o,
    output logic [DW-1:0] r1_q_o,
    // SRAM side
    input  logic [DW-1:0] sram_q_i,
    output logic [AW-1:0] sram_a_o,
    output logic [DW-1:0] sram_d_o,
    output logic          sram_wen_o,
    output logic          lock_abort_o
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t     owner_q,      owner_d;
    logic       rr_ptr_q,     rr_ptr_d;     // 0: R0 wins next tie, 1: R1
    logic [7:0] lock_cnt_q,   lock_cnt_d;
    logic [1:0] rd_pend_q,    rd_pend_d;
    logic       lock_abort_q, lock_abort_d;

    logic gnt0;
    logic gnt1;
    logic own_lock;   // lock request of the current owner

    // ------------------------------------------------------------------
    // Grant: the lock owner is the only candidate; otherwise round-robin.
    // Nothing is granted while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_i) begin
            case (owner_q)
                OWN_R0:  gnt0 = r0_req_i;
                OWN_R1:  gnt1 = r1_req_i;
                default: begin
                    if (r0_req_i && r1_req_i) begin
                        gnt0 = ~rr_ptr_q;
                        gnt1 =  rr_ptr_q;
                    end else begin
                        gnt0 = r0_req_i;
                        gnt1 = r1_req_i;
                    end
                end
            endcase
        end
    end

    // SRAM pin mux; the idle cycle is a discarded read of address 0.
    always_comb begin
        sram_a_o   = '0;
        sram_d_o   = '0;
        sram_wen_o = 1'b1;
        if (gnt1) begin
            sram_a_o   = r1_a_i;
            sram_d_o   = r1_d_i;
            sram_wen_o = r1_wen_i;
        end else if (gnt0) begin
            sram_a_o   = r0_a_i;
            sram_d_o   = r0_d_i;
            sram_wen_o = r0_wen_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: round-robin pointer, lock ownership, read tracking
    // ------------------------------------------------------------------
    always_comb begin
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        lock_cnt_d   = lock_cnt_q;
        lock_abort_d = 1'b0;
        rd_pend_d    = {gnt1 & r1_wen_i, gnt0 & r0_wen_i};
        own_lock     = (owner_q == OWN_R0) ? r0_lock_i : r1_lock_i;

        case (owner_q)
            OWN_NONE: begin
                if (gnt0) begin
                    rr_ptr_d = 1'b1;
                    if (r0_lock_i) begin
                        owner_d    = OWN_R0;
                        lock_cnt_d = 8'd1;
                    end
                end else if (gnt1) begin
                    rr_ptr_d = 1'b0;
                    if (r1_lock_i) begin
                        owner_d    = OWN_R1;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            OWN_R0, OWN_R1: begin
                // The counter advances every locked cycle, requesting or not.
                if (!own_lock || (lock_cnt_q >= MAX_LOCK_C)) begin
                    owner_d      = OWN_NONE;
                    lock_cnt_d   = 8'd0;
                    rr_ptr_d     = (owner_q == OWN_R0);
                    lock_abort_d = own_lock;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: begin
                owner_d    = OWN_NONE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q      <= OWN_NONE;
            rr_ptr_q     <= 1'b0;
            lock_cnt_q   <= 8'd0;
            rd_pend_q    <= 2'b00;
            lock_abort_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            lock_abort_q <= lock_abort_d;
        end
    end

    assign r0_gnt_o     = gnt0;
    assign r1_gnt_o     = gnt1;
    assign r0_rvalid_o  = rd_pend_q[0];
    assign r1_rvalid_o  = rd_pend_q[1];
    assign r0_q_o       = sram_q_i;
    assign r1_q_o       = sram_q_i;
    assign lock_abort_o = lock_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_cle_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cle_sram_arbiter
// Purpose  : Self-checking bench for cle_sram_arbiter with a behavioural
//            1024x8 write-first SRAM model on the SRAM pins.
// Revision : 1.0  initial release
// ============================================================================
module tb_cle_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct packed {
        logic          rst;
        logic          q0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          q1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          l1;
        logic          g0, g1, swen;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          rv0, rv1;
        logic [DW-1:0] q;
        logic          ab;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          r0_req, r0_wen, r0_lock, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_a;
    logic [DW-1:0] r0_d, r0_q;
    logic          r1_req, r1_wen, r1_lock, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_a;
    logic [DW-1:0] r1_d, r1_q;
    logic [DW-1:0] sram_q;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic          sram_wen;
    logic          lock_abort;

    cle_sram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .r0_req_i(r0_req), .r0_wen_i(r0_wen), .r0_a_i(r0_a), .r0_d_i(r0_d),
        .r0_lock_i(r0_lock), .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid), .r0_q_o(r0_q),
        .r1_req_i(r1_req), .r1_wen_i(r1_wen), .r1_a_i(r1_a), .r1_d_i(r1_d),
        .r1_lock_i(r1_lock), .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid), .r1_q_o(r1_q),
        .sram_q_i(sram_q), .sram_a_o(sram_a), .sram_d_o(sram_d),
        .sram_wen_o(sram_wen), .lock_abort_o(lock_abort)
    );

    function automatic logic [DW-1:0] ival(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Behavioural SRAM: write-first, registered read data.
    logic [DW-1:0] mem [0:1023];
    logic          seed;
    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ival(AW'(i));
        end else if (!sram_wen) begin
            mem[sram_a] <= sram_d;
        end
        sram_q <= sram_wen ? mem[sram_a] : sram_d;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t V(
        input logic rst,
        input logic q0, input logic w0, input logic [AW-1:0] a0,
        input logic [DW-1:0] d0, input logic l0,
        input logic q1, input logic w1, input logic [AW-1:0] a1,
        input logic [DW-1:0] d1, input logic l1,
        input logic g0, input logic g1, input logic swen,
        input logic [AW-1:0] sa, input logic [DW-1:0] sd,
        input logic rv0, input logic rv1, input logic [DW-1:0] q, input logic ab);
        vec_t v;
        v.rst = rst;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.g0 = g0; v.g1 = g1; v.swen = swen; v.sa = sa; v.sd = sd;
        v.rv0 = rv0; v.rv1 = rv1; v.q = q; v.ab = ab;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, check mid-cycle.
    task automatic run_vec(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        reset  = v.rst;
        r0_req = v.q0; r0_wen = v.w0; r0_a = v.a0; r0_d = v.d0; r0_lock = v.l0;
        r1_req = v.q1; r1_wen = v.w1; r1_a = v.a1; r1_d = v.d1; r1_lock = v.l1;
        @(negedge clk);
        chk(tag, "r0_gnt",     32'(r0_gnt),     32'(v.g0));
        chk(tag, "r1_gnt",     32'(r1_gnt),     32'(v.g1));
        chk(tag, "sram_wen",   32'(sram_wen),   32'(v.swen));
        chk(tag, "sram_a",     32'(sram_a),     32'(v.sa));
        chk(tag, "sram_d",     32'(sram_d),     32'(v.sd));
        chk(tag, "r0_rvalid",  32'(r0_rvalid),  32'(v.rv0));
        chk(tag, "r1_rvalid",  32'(r1_rvalid),  32'(v.rv1));
        chk(tag, "lock_abort", 32'(lock_abort), 32'(v.ab));
        if (v.rv0) chk(tag, "r0_q", 32'(r0_q), 32'(v.q));
        if (v.rv1) chk(tag, "r1_q", 32'(r1_q), 32'(v.q));
    endtask

    vec_t          tbl [15];
    vec_t          v;
    logic [DW-1:0] exp_mem [0:1023];
    logic [AW-1:0] ai;

    initial begin
        reset = 1'b1; seed = 1'b1;
        r0_req = 1'b0; r0_wen = 1'b1; r0_a = '0; r0_d = '0; r0_lock = 1'b0;
        r1_req = 1'b0; r1_wen = 1'b1; r1_a = '0; r1_d = '0; r1_lock = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = ival(AW'(i));
        exp_mem[33] = 8'h05;
        exp_mem[40] = 8'hC3;
        repeat (2) @(posedge clk);
        #1 seed = 1'b0;

        //            rst  r0: req wen addr    data  lk  r1: req wen addr    data  lk   g0 g1 wen  sa      sd     rv0 rv1 q           ab
        tbl[0]  = V(Y,  Y,N,10'd33, 8'h05,N,  N,Y,10'd0,  8'h00,N,  N,N,Y,10'd0,  8'h00, N,N,8'h00,      N);
        tbl[1]  = V(N,  Y,N,10'd33, 8'h05,N,  N,Y,10'd0,  8'h00,N,  Y,N,N,10'd33, 8'h05, N,N,8'h00,      N);
        tbl[2]  = V(N,  Y,Y,10'd33, 8'h00,N,  N,Y,10'd0,  8'h00,N,  Y,N,Y,10'd33, 8'h00, N,N,8'h00,      N);
        tbl[3]  = V(N,  N,Y,10'd0,  8'h00,N,  N,Y,10'd0,  8'h00,N,  N,N,Y,10'd0,  8'h00, Y,N,8'h05,      N);
        tbl[4]  = V(Y,  N,Y,10'd0,  8'h00,N,  N,Y,10'd0,  8'h00,N,  N,N,Y,10'd0,  8'h00, N,N,8'h00,      N);
        tbl[5]  = V(N,  Y,Y,10'd100,8'h00,N,  Y,Y,10'd200,8'h00,N,  Y,N,Y,10'd100,8'h00, N,N,8'h00,      N);
        tbl[6]  = V(N,  Y,Y,10'd100,8'h00,N,  Y,Y,10'd200,8'h00,N,  N,Y,Y,10'd200,8'h00, Y,N,ival(10'd100),N);
        tbl[7]  = V(N,  Y,Y,10'd100,8'h00,N,  Y,Y,10'd200,8'h00,N,  Y,N,Y,10'd100,8'h00, N,Y,ival(10'd200),N);
        tbl[8]  = V(N,  Y,Y,10'd100,8'h00,N,  Y,Y,10'd200,8'h00,N,  N,Y,Y,10'd200,8'h00, Y,N,ival(10'd100),N);
        tbl[9]  = V(N,  Y,Y,10'd40, 8'h00,Y,  Y,Y,10'd200,8'h00,N,  Y,N,Y,10'd40, 8'h00, N,Y,ival(10'd200),N);
        tbl[10] = V(N,  Y,N,10'd40, 8'hC3,Y,  Y,Y,10'd200,8'h00,N,  Y,N,N,10'd40, 8'hC3, Y,N,ival(10'd40), N);
        tbl[11] = V(N,  Y,Y,10'd40, 8'h00,N,  Y,Y,10'd200,8'h00,N,  Y,N,Y,10'd40, 8'h00, N,N,8'h00,      N);
        tbl[12] = V(N,  Y,Y,10'd40, 8'h00,N,  Y,Y,10'd200,8'h00,N,  N,Y,Y,10'd200,8'h00, Y,N,8'hC3,      N);
        tbl[13] = V(N,  Y,Y,10'd40, 8'h00,N,  N,Y,10'd0,  8'h00,N,  Y,N,Y,10'd40, 8'h00, N,Y,ival(10'd200),N);
        tbl[14] = V(N,  N,Y,10'd0,  8'h00,N,  N,Y,10'd0,  8'h00,N,  N,N,Y,10'd0,  8'h00, Y,N,8'hC3,      N);

        for (int i = 0; i < 15; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // r1 holds its lock until the timeout forces it off; r0 waits throughout.
        run_vec("lock0", V(N, Y,Y,10'd5,8'h00,N, Y,Y,10'd7,8'h00,Y, N,Y,Y,10'd7,8'h00, N,N,8'h00,N));
        for (int i = 1; i <= 4; i++)
            run_vec($sformatf("lock%0d", i),
                    V(N, Y,Y,10'd5,8'h00,N, Y,Y,10'd7,8'h00,Y, N,Y,Y,10'd7,8'h00, N,Y,ival(10'd7),N));
        run_vec("lock5", V(N, Y,Y,10'd5,8'h00,N, Y,Y,10'd7,8'h00,Y, Y,N,Y,10'd5,8'h00, N,Y,ival(10'd7),Y));
        run_vec("lock6", V(N, Y,Y,10'd5,8'h00,N, Y,Y,10'd7,8'h00,N, N,Y,Y,10'd7,8'h00, Y,N,ival(10'd5),N));

        // Reset while r0 holds the lock with a read in flight.
        run_vec("rst0", V(N, Y,Y,10'd9,8'h00,Y, N,Y,10'd0, 8'h00,N, Y,N,Y,10'd9, 8'h00, N,Y,ival(10'd7),N));
        run_vec("rst1", V(N, Y,Y,10'd9,8'h00,Y, Y,Y,10'd11,8'h00,N, Y,N,Y,10'd9, 8'h00, Y,N,ival(10'd9),N));
        run_vec("rst2", V(Y, Y,Y,10'd9,8'h00,Y, Y,Y,10'd11,8'h00,N, N,N,Y,10'd0, 8'h00, N,N,8'h00,N));
        run_vec("rst3", V(N, N,Y,10'd0,8'h00,N, Y,Y,10'd11,8'h00,N, N,Y,Y,10'd11,8'h00, N,N,8'h00,N));
        run_vec("rst4", V(N, N,Y,10'd0,8'h00,N, N,Y,10'd0, 8'h00,N, N,N,Y,10'd0, 8'h00, N,Y,ival(10'd11),N));

        for (int i = 0; i < 5; i++)
            run_vec($sformatf("idle%0d", i),
                    V(N, N,Y,10'd0,8'h00,N, N,Y,10'd0,8'h00,N, N,N,Y,10'd0,8'h00, N,N,8'h00,N));

        // Full dump through r0: read address i, expect the word of address i-1.
        for (int i = 0; i <= 1024; i++) begin
            ai = AW'(i);
            v = V(N, (i < 1024) ? Y : N, Y, ai, 8'h00, N,
                  N, Y, 10'd0, 8'h00, N,
                  (i < 1024) ? Y : N, N, Y, (i < 1024) ? ai : 10'd0, 8'h00,
                  (i > 0) ? Y : N, N, (i > 0) ? exp_mem[AW'(i - 1)] : 8'h00, N);
            run_vec($sformatf("dump%0d", i), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cle_sram_arbiter.md
Name: cle_sram_arbiter

Overview:
- Shares the single-port 1024x8 label SRAM between two requesters.
- Requester 0 is the CLE labeling/merge core. Requester 1 is the result-dump/clear engine.
- Arbitration is per cycle and round-robin. A lock lets one requester keep the port for atomic read-modify-write label merges.
- Sits between the requesters and the SRAM's A/D/WEN/Q pins; the SRAM CEN is tied low.

Parameters:
- AW, 10, SRAM address width (1024 words)
- DW, 8, SRAM data/label width
- MAX_LOCK, 16, maximum consecutive locked cycles before forced release (1..255)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  requester 0 access request, valid this cycle
- r0_wen  in  1  requester 0 write enable, active-low (0 = write, 1 = read), same sense as SRAM
- r0_a  in  AW  requester 0 address
- r0_d  in  DW  requester 0 write data
- r0_lock  in  1  requester 0 asks to keep ownership next cycle
- r0_gnt  out  1  requester 0 access accepted this cycle (combinational)
- r0_rvalid  out  1  read data for requester 0 valid this cycle
- r0_q  out  DW  read data to requester 0
- r1_req, r1_wen, r1_a, r1_d, r1_lock, r1_gnt, r1_rvalid, r1_q  same as above, for requester 1
- sram_q  in  DW  SRAM read data, valid the cycle after a read edge
- sram_a  out  AW  SRAM address
- sram_d  out  DW  SRAM write data
- sram_wen  out  1  SRAM write enable, active-low
- lock_abort  out  1  one-cycle pulse when a lock is forcibly released by the MAX_LOCK timeout

Behaviour:
- State:
  - rr_ptr: the requester that has priority on the next tie.
  - owner: NONE/R0/R1, the lock owner.
  - lock_cnt: 8-bit counter.
  - rd_pend[1:0]: registered flags for read data in flight.
- Reset (async, any time):
  - rr_ptr = 0, owner = NONE, lock_cnt = 0, rd_pend = 0, lock_abort = 0.
  - Combinational outputs during reset: r*_gnt = 0, sram_wen = 1, sram_a = 0, sram_d = 0.
  - Reset mid-access cancels any pending rvalid.
- Grant, combinational in the same cycle:
  - owner = Rk: only Rk can be granted; the other requester waits regardless of rr_ptr.
  - owner = NONE, single request: grant it.
  - owner = NONE, both requesting: grant rr_ptr.
  - No request: no grant. Drive sram_wen = 1, sram_a = 0, sram_d = 0 (idle read of address 0; its result is discarded).
- Mux: sram_a, sram_d and sram_wen follow the granted requester. The SRAM samples them at the next posedge.
- rr_ptr: after any granted cycle with owner = NONE, rr_ptr = the other requester. It is unchanged while a lock is held.
- Lock FSM:
  - NONE -> Rk when Rk is granted with rk_lock = 1. lock_cnt = 1.
  - Rk -> Rk while rk_lock = 1 and lock_cnt < MAX_LOCK. lock_cnt increments each cycle, whether or not Rk requests.
  - Rk -> NONE when rk_lock = 0. After release, rr_ptr = the other requester.
  - Rk -> NONE when lock_cnt = MAX_LOCK and rk_lock = 1 (forced release). lock_abort pulses for 1 cycle; rr_ptr = the other requester.
- Read latency:
  - A granted read (wen = 1) at edge N gives rk_rvalid = 1 in cycle N+1, with rk_q = sram_q.
  - rk_q equals sram_q at all times; it is only meaningful while rvalid = 1.
  - Writes never raise rvalid.
  - Back-to-back reads are supported at 1 per cycle.
- Same-address write-then-read on consecutive cycles returns the new data, because the SRAM is write-first across edges. No forwarding logic is needed.
- A requester must hold req/wen/a/d stable until it sees gnt. Ungranted requests have no side effect.
- Throughput: 1 access per cycle in total. Without locks, no requester waits more than 1 cycle while the other is also requesting.

Test Plan:
- Reset, then r0 writes 8'h05 at addr 10'd33 alone -> r0_gnt = 1 the same cycle, sram_wen = 0, sram_a = 33. Then an r0 read of 33 -> r0_rvalid next cycle, r0_q = 8'h05.
- r0 and r1 both request reads continuously, starting from reset -> grants alternate R0, R1, R0, R1. Each rvalid comes 1 cycle after its grant. r1 never waits more than 1 cycle.
- r0 holds lock for 3 cycles doing read 40 / write 40 / read 40 while r1 requests throughout -> r1_gnt = 0 for those 3 cycles. After r0_lock drops, r1 is granted on the next cycle.
- MAX_LOCK = 4; r1 holds lock with continuous requests -> forced release after 4 cycles, lock_abort = 1 for 1 cycle, and r0 is granted the next cycle.
- Assert reset for 1 cycle while r0's read is in flight, with lock held -> r0_rvalid = 0 the next cycle, owner = NONE, sram_wen = 1, rr_ptr = 0.
- No requests for 5 cycles -> sram_wen = 1 throughout, no gnt, no rvalid, SRAM contents unchanged (checked by a full 1024-word dump).
